// File: rtl/mandelbrot_iter.sv
// Escape-time iterator for one pixel: z <- z^2 + c from z = 0 in signed Q4.28.
// o_result = {valid, count}; a count of MAX_ITER means the point is in the set.
module mandelbrot_iter #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 28,
    parameter int MAX_ITER = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_cre,
    input  logic [WIDTH-1:0] i_cim,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic signed [2*WIDTH:0] ESC_LIM =
        (2*WIDTH+1)'(4) << (2*FRAC);

    state_t r_state;
    state_t w_next;

    logic signed [WIDTH-1:0]   r_cr;
    logic signed [WIDTH-1:0]   r_ci;
    logic signed [WIDTH-1:0]   r_zr;
    logic signed [WIDTH-1:0]   r_zi;
    logic [6:0]                r_n;
    logic [7:0]                r_result;

    logic signed [2*WIDTH-1:0] w_pr;
    logic signed [2*WIDTH-1:0] w_pi;
    logic signed [2*WIDTH-1:0] w_px;
    logic signed [2*WIDTH-1:0] w_diff;
    logic signed [2*WIDTH:0]   w_mag;
    logic signed [WIDTH-1:0]   w_zr_nxt;
    logic signed [WIDTH-1:0]   w_zi_nxt;
    logic                      w_escape;
    logic                      w_limit;

    assign w_pr = (2*WIDTH)'(r_zr) * (2*WIDTH)'(r_zr);
    assign w_pi = (2*WIDTH)'(r_zi) * (2*WIDTH)'(r_zi);
    assign w_px = (2*WIDTH)'(r_zr) * (2*WIDTH)'(r_zi);

    assign w_mag  = (2*WIDTH+1)'(w_pr) + (2*WIDTH+1)'(w_pi);
    assign w_diff = w_pr - w_pi;

    // Shifting px by FRAC-1 folds in the factor of two of 2*zr*zi.
    assign w_zr_nxt = WIDTH'(w_diff >>> FRAC) + r_cr;
    assign w_zi_nxt = WIDTH'(w_px >>> (FRAC - 1)) + r_ci;

    assign w_escape = w_mag > ESC_LIM;
    assign w_limit  = r_n == 7'(MAX_ITER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_ITER;
                end
            end
            S_ITER: begin
                o_busy = 1'b1;
                if (w_escape || w_limit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cr     <= '0;
            r_ci     <= '0;
            r_zr     <= '0;
            r_zi     <= '0;
            r_n      <= '0;
            r_result <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cr <= i_cre;
                        r_ci <= i_cim;
                        r_zr <= '0;
                        r_zi <= '0;
                        r_n  <= '0;
                    end
                end
                S_ITER: begin
                    if (w_escape) begin
                        r_result <= {1'b1, r_n};
                    end else if (w_limit) begin
                        r_result <= {1'b1, 7'(MAX_ITER)};
                    end else begin
                        r_zr <= w_zr_nxt;
                        r_zi <= w_zi_nxt;
                        r_n  <= r_n + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_result;

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Bench for mandelbrot_iter: expected results queued at start, checked on o_done.
// Latency counts negedges after the start edge; o_done is expected at count k+2.
module tb_mandelbrot_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_cre;
    logic [31:0] i_cim;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_result;

    typedef struct {
        logic [7:0] res;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    mandelbrot_iter dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_cre    (i_cre),
        .i_cim    (i_cim),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_done) done_cnt++;
    end

    // Called at a negedge in IDLE; returns at the first negedge after the start edge.
    task automatic start_px(input logic [31:0] cr, input logic [31:0] ci,
                            input logic [7:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.lat = lat;
        i_cre = cr;
        i_cim = ci;
        i_start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
        i_cre = $urandom;
        i_cim = $urandom;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit got);
        got = 1'b0;
        lat = 1;
        while (lat <= budget) begin
            if (o_done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b0;
        i_cre = '0;
        i_cim = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h, need 0 0 00",
                     o_busy, o_done, o_result);
        end
        repeat (5) @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || done_cnt !== 0) begin
            bad++;
            $display("FAIL reset_idle_hold: busy=%b pulses=%0d, need 0 0",
                     o_busy, done_cnt);
        end
    endtask

    task automatic check_px(input string name);
        int   lat;
        bit   got;
        exp_t e;
        wait_done(200, lat, got);
        e = sb.pop_front();
        total++;
        if (!got || lat !== e.lat) begin
            bad++;
            $display("FAIL %s_latency: got=%0d lat=%0d, need lat=%0d",
                     name, got, lat, e.lat);
        end
        total++;
        if (o_result !== e.res || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_result: result=%h busy=%b, need %h busy=1",
                     name, o_result, o_busy, e.res);
        end
    endtask

    task automatic test_escape();
        int n0;
        n0 = done_cnt;
        start_px(32'h1000_0000, 32'h0, 8'h83, 5);
        check_px("c_one");
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h83) begin
            bad++;
            $display("FAIL c_one_after: busy=%b done=%b result=%h, need 0 0 83",
                     o_busy, o_done, o_result);
        end
        total++;
        if (done_cnt - n0 !== 1) begin
            bad++;
            $display("FAIL c_one_pulses: pulses=%0d, need 1", done_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start_px(32'h0800_0000, 32'h0, 8'h85, 7);
        check_px("c_half");
        @(negedge clk);
        start_px(32'h0, 32'h0, 8'hE3, 101);
        total++;
        if (o_result !== 8'h85) begin
            bad++;
            $display("FAIL hold_in_iter: result=%h, need 85", o_result);
        end
        check_px("c_zero_b2b");
    endtask

    task automatic test_boundary();
        @(negedge clk);
        @(negedge clk);
        start_px(32'hE000_0000, 32'h0, 8'hE3, 101);
        check_px("c_minus_two");
        @(negedge clk);
        @(negedge clk);
        start_px(32'h0, 32'h1000_0000, 8'hE3, 101);
        check_px("c_i");
    endtask

    task automatic test_start_while_busy();
        int   lat;
        int   n0;
        bit   got;
        exp_t e;
        @(negedge clk);
        @(negedge clk);
        n0 = done_cnt;
        start_px(32'h0, 32'h0, 8'hE3, 101);
        got = 1'b0;
        lat = 1;
        while (lat <= 200) begin
            if (o_done) begin
                got = 1'b1;
                break;
            end
            i_start = (lat == 3 || lat == 50);
            i_cre = 32'h1000_0000;
            i_cim = 32'h0;
            @(negedge clk);
            i_start = 1'b0;
            lat++;
        end
        e = sb.pop_front();
        total++;
        if (!got || lat !== e.lat || o_result !== e.res) begin
            bad++;
            $display("FAIL busy_start: got=%0d lat=%0d result=%h, need lat=%0d %h",
                     got, lat, o_result, e.lat, e.res);
        end
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt - n0 !== 1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_pulses: pulses=%0d busy=%b, need 1 0",
                     done_cnt - n0, o_busy);
        end
    endtask

    task automatic test_reset_abort();
        int n0;
        n0 = done_cnt;
        start_px(32'h0, 32'h0, 8'hE3, 101);
        repeat (39) @(negedge clk);
        total++;
        if (o_busy !== 1'b1 || o_result !== 8'hE3) begin
            bad++;
            $display("FAIL abort_pre: busy=%b result=%h, need 1 e3", o_busy, o_result);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00) begin
            bad++;
            $display("FAIL abort_reset: busy=%b done=%b result=%h, need 0 0 00",
                     o_busy, o_done, o_result);
        end
        repeat (120) @(negedge clk);
        total++;
        if (done_cnt !== n0 || o_result !== 8'h00) begin
            bad++;
            $display("FAIL abort_no_pulse: pulses=%0d result=%h, need 0 00",
                     done_cnt - n0, o_result);
        end
        start_px(32'h0, 32'h0, 8'hE3, 101);
        check_px("after_abort");
    endtask

    initial begin
        test_reset();
        test_escape();
        test_back_to_back();
        test_boundary();
        test_start_while_busy();
        test_reset_abort();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mandelbrot_iter.md
Name: mandelbrot_iter

Overview:
- Escape-time iteration engine for one pixel. It takes a complex constant c, iterates z <- z^2 + c from z = 0, and reports the iteration count.
- The result byte is the colour-lookup input of the palette stage, which sits directly downstream: bit 7 is the valid flag and bits [6:0] are the iteration count.
- A count equal to MAX_ITER marks "in set", which the palette shows as black in B&W mode.
- The block is started once per pixel by the scan/address sequencer upstream.

Parameters:
- WIDTH, 32: signed fixed-point word width for c and z.
- FRAC, 28: fractional bits (Q4.28; representable range ±8).
- MAX_ITER, 99: iteration limit. Must be ≤ 127 to fit o_result[6:0].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_cre  in  WIDTH  real part of c, signed Q4.28; caller guarantees |i_cre| ≤ 2.0.
- i_cim  in  WIDTH  imaginary part of c, signed Q4.28; caller guarantees |i_cim| ≤ 2.0.
- o_busy  out  1  high in ITER and DONE.
- o_done  out  1  single-cycle pulse; o_result is new and valid in this cycle.
- o_result  out  8  {1'b1, iter[6:0]} after the first completion; held until the next completion.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE, o_busy = 0, o_done = 0, o_result = 8'h00 (valid bit 0, so the palette outputs black), zr = zi = 0, n = 0.
- States: IDLE -> ITER -> DONE -> IDLE.
- IDLE:
  - On i_start = 1, latch i_cre/i_cim into cr/ci, clear zr, zi and n, and go to ITER.
  - Otherwise stay in IDLE.
- ITER (one iteration per cycle):
  - Compute full-precision 2*WIDTH-bit products: pr = zr*zr, pi = zi*zi, px = zr*zi.
  - Form mag = pr + pi in 2*WIDTH+1 bits.
  - Escape when mag > 4.0 scaled, i.e. 4 << (2*FRAC). The comparison is strict: mag equal to 4.0 does not escape.
  - If escape: capture n, go to DONE.
  - Else if n == MAX_ITER: capture MAX_ITER, go to DONE.
  - Else update, with products arithmetically shifted right by FRAC and truncated to WIDTH:
    - zr <= (pr - pi) >>> FRAC + cr
    - zi <= (px >>> (FRAC - 1)) + ci
    - n <= n + 1
  - No saturation logic. The input bounds plus the pre-update escape check keep |zr| and |zi| ≤ 6, so there is no overflow in Q4.28.
- DONE:
  - o_done = 1 for exactly this cycle.
  - o_result = {1'b1, captured count[6:0]}, registered on entry to DONE.
  - Next state is IDLE. o_busy drops in the following cycle.
- Latency:
  - Start accepted at edge T0.
  - An escape decided with n = k takes k+1 ITER cycles.
  - o_done is high during cycle T0 + k + 2.
  - Non-escaping pixels: o_done is high at T0 + MAX_ITER + 2 (T0 + 101 at default).
  - Back-to-back pixels: the next i_start is accepted in the IDLE cycle after DONE. Throughput is one pixel per (k + 3) cycles.
- i_start while busy: ignored, with no effect on state, c, or the count. The caller must reassert it in IDLE.
- i_cre/i_cim may change freely after the start cycle; only the latched values are used.
- o_result keeps its last value through IDLE and the next ITER. It changes only on DONE entry or reset.
- Reset mid-ITER or mid-DONE: abort immediately. No o_done pulse; o_result returns to 8'h00.

Test Plan:
1. rst for 2 cycles, then idle: o_busy = 0, o_done = 0, o_result = 8'h00; i_start held low leaves the state in IDLE.
2. c = 1.0 + 0i (i_cre = 32'h1000_0000, i_cim = 0): z goes 0, 1, 2 (mag = 4.0, no escape), 5 (escape at n = 3) -> o_result = 8'h83, o_done high exactly at T0 + 5.
3. c = 0.5 + 0i (32'h0800_0000): escape at n = 5 (|z|^2 ≈ 9.94) -> o_result = 8'h85 at T0 + 7. Then c = 0 started the cycle after returning to IDLE -> o_result = 8'hE3 at its own T0 + 101.
4. c = -2.0 + 0i and c = 0 + 1.0i: mag stays ≤ 4.0, with the boundary hit every cycle for -2.0 -> o_result = 8'hE3 (99) at T0 + 101. Checks the strict compare and signed arithmetic.
5. i_start pulsed at T0 + 3 and T0 + 50 during c = 0 -> single o_done at T0 + 101, result 8'hE3, no extra pulse.
6. rst asserted at T0 + 40 during c = 0 -> no o_done, o_result = 8'h00 and o_busy = 0 the cycle after the reset edge. A new start then completes normally with 8'hE3.
